srsw_ram_arbiter: RTL and testbench

- Shares one single-read/single-write RAM port pair (registered read data) among NREQ requesters.
- Two independent round-robin arbiters run side by side, one for the write port and one for the read port.
- Each granted read's data is routed back to the requester that issued it.
- Halt-aware, so it sits between emulated-DUT logic and an srsw_rdata-style memory that freezes under halt.

---
 rtl/srsw_ram_arbiter_if.sv | 44 ++++
 rtl/srsw_ram_arbiter.sv | 152 +++++++++++++++
 tb/tb_srsw_ram_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/srsw_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : srsw_ram_arbiter_if
//  Description : Requester-side handshake bus plus RAM-side port bundle for
//                srsw_ram_arbiter. The arbiter binds to the slave modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface srsw_ram_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 2,
    parameter int DW   = 32
);
    // requester side
    logic [NREQ-1:0]    wr_valid;
    logic [NREQ-1:0]    wr_ready;
    logic [NREQ*AW-1:0] wr_addr;
    logic [NREQ*DW-1:0] wr_data;
    logic [NREQ-1:0]    rd_valid;
    logic [NREQ-1:0]    rd_ready;
    logic [NREQ*AW-1:0] rd_addr;
    logic [NREQ-1:0]    resp_valid;
    logic [DW-1:0]      resp_data;

    // memory side
    logic               ram_wen;
    logic [AW-1:0]      ram_waddr;
    logic [DW-1:0]      ram_wdata;
    logic               ram_ren;
    logic [AW-1:0]      ram_raddr;
    logic [DW-1:0]      ram_rdata;

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_rdata,
        output wr_ready, rd_ready, resp_valid, resp_data,
               ram_wen, ram_waddr, ram_wdata, ram_ren, ram_raddr
    );

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_rdata,
        input  wr_ready, rd_ready, resp_valid, resp_data,
               ram_wen, ram_waddr, ram_wdata, ram_ren, ram_raddr
    );
endinterface
`default_nettype wire

// File: rtl/srsw_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : srsw_ram_arbiter
//  Description : Shares one single-read/single-write RAM (registered read
//                data) among NREQ requesters with independent round-robin
//                write and read arbiters; halt freezes all activity.
//                Define SRSW_ARB_BYPASS_EN for write-first same-address
//                read/write collisions.
//  Revision    : 1.0 - initial release
// ============================================================================
module srsw_ram_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 2,
    parameter int DW   = 32
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           halt,
    srsw_ram_arbiter_if.slave   bus
);

    localparam int                c_PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [c_PW-1:0]   c_PTR_RST  = c_PW'(NREQ - 1);

    // Returns {hit, index}; scan runs from lowest priority to highest so the
    // highest-priority requester (ptr+1) is the last to overwrite the result.
    function automatic logic [c_PW:0] f_rr_pick(
        input logic [NREQ-1:0] req,
        input logic [c_PW-1:0] ptr
    );
        logic [c_PW:0] res;
        int            idx;
        res = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[c_PW'(idx)]) begin
                res = {1'b1, c_PW'(idx)};
            end
        end
        return res;
    endfunction

    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic            r_pend;
    logic [c_PW-1:0] r_pend_id;

    logic            w_gnt_en;
    logic [c_PW:0]   w_wr_pick;
    logic [c_PW:0]   w_rd_pick;
    logic            w_wr_vld;
    logic            w_rd_vld;
    logic [c_PW-1:0] w_wr_idx;
    logic [c_PW-1:0] w_rd_idx;
    logic [NREQ-1:0] w_wr_oh;
    logic [NREQ-1:0] w_rd_oh;
    logic [AW-1:0]   w_ram_waddr;
    logic [DW-1:0]   w_ram_wdata;
    logic [AW-1:0]   w_ram_raddr;
    logic            w_resp_en;
    logic [DW-1:0]   w_rd_src;

    // rst and halt both suppress every grant and response
    assign w_gnt_en  = !rst && !halt;

    assign w_wr_pick = f_rr_pick(bus.wr_valid, r_wr_ptr);
    assign w_rd_pick = f_rr_pick(bus.rd_valid, r_rd_ptr);

    assign w_wr_vld  = w_gnt_en && w_wr_pick[c_PW];
    assign w_rd_vld  = w_gnt_en && w_rd_pick[c_PW];
    assign w_wr_idx  = w_wr_pick[c_PW-1:0];
    assign w_rd_idx  = w_rd_pick[c_PW-1:0];

    assign w_wr_oh   = w_wr_vld ? (NREQ'(1) << w_wr_idx) : '0;
    assign w_rd_oh   = w_rd_vld ? (NREQ'(1) << w_rd_idx) : '0;

    // One-hot AND-OR muxes; all-zero when no grant
    always_comb begin
        w_ram_waddr = '0;
        w_ram_wdata = '0;
        w_ram_raddr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_wr_oh[i]) begin
                w_ram_waddr = w_ram_waddr | bus.wr_addr[i*AW +: AW];
                w_ram_wdata = w_ram_wdata | bus.wr_data[i*DW +: DW];
            end
            if (w_rd_oh[i]) begin
                w_ram_raddr = w_ram_raddr | bus.rd_addr[i*AW +: AW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= c_PTR_RST;
            r_rd_ptr  <= c_PTR_RST;
            r_pend    <= 1'b0;
            r_pend_id <= '0;
        end else if (!halt) begin
            if (w_wr_vld) begin
                r_wr_ptr <= w_wr_idx;
            end
            if (w_rd_vld) begin
                r_rd_ptr  <= w_rd_idx;
                r_pend_id <= w_rd_idx;
            end
            r_pend <= w_rd_vld;
        end
    end

`ifdef SRSW_ARB_BYPASS_EN
    logic          r_byp_flag;
    logic [DW-1:0] r_byp_data;
    logic          w_collide;

    assign w_collide = w_wr_vld && w_rd_vld && (w_ram_waddr == w_ram_raddr);

    // Flag tracks the outstanding read, so it only moves when a read is granted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byp_flag <= 1'b0;
            r_byp_data <= '0;
        end else if (!halt && w_rd_vld) begin
            r_byp_flag <= w_collide;
            if (w_collide) begin
                r_byp_data <= w_ram_wdata;
            end
        end
    end

    assign w_rd_src = r_byp_flag ? r_byp_data : bus.ram_rdata;
`else
    assign w_rd_src = bus.ram_rdata;
`endif

    assign w_resp_en      = r_pend && w_gnt_en;

    assign bus.wr_ready   = w_wr_oh;
    assign bus.rd_ready   = w_rd_oh;
    assign bus.ram_wen    = w_wr_vld;
    assign bus.ram_waddr  = w_ram_waddr;
    assign bus.ram_wdata  = w_ram_wdata;
    assign bus.ram_ren    = w_rd_vld;
    assign bus.ram_raddr  = w_ram_raddr;
    assign bus.resp_valid = w_resp_en ? (NREQ'(1) << r_pend_id) : '0;
    assign bus.resp_data  = w_resp_en ? w_rd_src : '0;

endmodule
`default_nettype wire

// File: tb/tb_srsw_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_srsw_ram_arbiter
//  Description : Directed self-checking bench for srsw_ram_arbiter with a
//                registered-read RAM model (NREQ=2, AW=2, DW=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_srsw_ram_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 2;
    localparam int DW   = 32;

    logic clk;
    logic rst;
    logic halt;

    srsw_ram_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    srsw_ram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk  (clk),
        .rst  (rst),
        .halt (halt),
        .bus  (bus.slave)
    );

    // Registered-read RAM, read-first on same-address collision
    logic [DW-1:0] mem [4];
    always @(posedge clk) begin
        if (bus.ram_ren) bus.ram_rdata <= mem[bus.ram_raddr];
        if (bus.ram_wen) mem[bus.ram_waddr] <= bus.ram_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_cmp;
    int            n_fail;
    logic [31:0]   ref_mem [4];
    logic [1:0]    prev_oh;
    logic [31:0]   prev_data;
    logic [1:0]    a0, a1;
    int            gid;
    logic [31:0]   exp_coll;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.wr_valid = '0;
        bus.rd_valid = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_addr  = '0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        halt   = 1'b0;
        idle_inputs();

        // reset with requests present: everything stays quiet
        @(negedge clk);
        bus.wr_valid = 2'b11;
        bus.rd_valid = 2'b11;
        #1;
        chk("rst_wr_ready", bus.wr_ready, 2'b00);
        chk("rst_rd_ready", bus.rd_ready, 2'b00);
        chk("rst_ram_wen",  bus.ram_wen, 1'b0);
        chk("rst_ram_ren",  bus.ram_ren, 1'b0);
        chk("rst_resp_vld", bus.resp_valid, 2'b00);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;

        // contention on writes: 0,1,0,1
        bus.wr_valid = 2'b11;
        bus.wr_addr  = {2'd1, 2'd0};
        bus.wr_data  = {32'h0000_000B, 32'h0000_000A};
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("wr_rr_ready", bus.wr_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("wr_rr_waddr", bus.ram_waddr, (i % 2 == 0) ? 2'd0 : 2'd1);
            chk("wr_rr_wdata", bus.ram_wdata, (i % 2 == 0) ? 32'hA : 32'hB);
            @(negedge clk);
        end
        ref_mem[0] = 32'hA;
        ref_mem[1] = 32'hB;

        // write DEADBEEF @2 by requester 1
        idle_inputs();
        bus.wr_valid = 2'b10;
        bus.wr_addr  = {2'd2, 2'd0};
        bus.wr_data  = {32'hDEAD_BEEF, 32'h0};
        #1;
        chk("wr1_ready", bus.wr_ready, 2'b10);
        chk("wr1_waddr", bus.ram_waddr, 2'd2);
        ref_mem[2] = 32'hDEAD_BEEF;

        // requester 0 reads @2
        @(negedge clk);
        idle_inputs();
        bus.rd_valid = 2'b01;
        bus.rd_addr  = {2'd0, 2'd2};
        #1;
        chk("rd0_ready",  bus.rd_ready, 2'b01);
        chk("rd0_raddr",  bus.ram_raddr, 2'd2);
        chk("idle_wen",   bus.ram_wen, 1'b0);
        chk("idle_waddr", bus.ram_waddr, 2'd0);
        chk("idle_wdata", bus.ram_wdata, 32'h0);
        chk("rd0_no_resp_yet", bus.resp_valid, 2'b00);

        @(negedge clk);
        idle_inputs();
        #1;
        chk("rd0_resp_vld",  bus.resp_valid, 2'b01);
        chk("rd0_resp_data", bus.resp_data, 32'hDEAD_BEEF);
        chk("rd0_ren_idle",  bus.ram_ren, 1'b0);

        @(negedge clk);
        #1;
        chk("resp_clears",      bus.resp_valid, 2'b00);
        chk("resp_data_zero",   bus.resp_data, 32'h0);

        // requester 1 reads @1, then halt for 3 cycles
        @(negedge clk);
        bus.rd_valid = 2'b10;
        bus.rd_addr  = {2'd1, 2'd0};
        #1;
        chk("rd1_ready", bus.rd_ready, 2'b10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            halt         = 1'b1;
            bus.wr_valid = 2'b11;
            bus.rd_valid = 2'b11;
            bus.wr_addr  = {2'd3, 2'd3};
            bus.wr_data  = {32'hBAD1, 32'hBAD0};
            #1;
            chk("halt_wr_ready", bus.wr_ready, 2'b00);
            chk("halt_rd_ready", bus.rd_ready, 2'b00);
            chk("halt_wen",      bus.ram_wen, 1'b0);
            chk("halt_ren",      bus.ram_ren, 1'b0);
            chk("halt_resp_vld", bus.resp_valid, 2'b00);
        end
        @(negedge clk);
        halt = 1'b0;
        idle_inputs();
        #1;
        chk("post_halt_resp_vld",  bus.resp_valid, 2'b10);
        chk("post_halt_resp_data", bus.resp_data, 32'hB);

        // seed @3 with 0x11 via requester 0
        @(negedge clk);
        bus.wr_valid = 2'b01;
        bus.wr_addr  = {2'd0, 2'd3};
        bus.wr_data  = {32'h0, 32'h11};
        #1;
        chk("seed_ready", bus.wr_ready, 2'b01);

        // same-cycle write 0x55 / read @3
        @(negedge clk);
        bus.wr_valid = 2'b01;
        bus.wr_addr  = {2'd0, 2'd3};
        bus.wr_data  = {32'h0, 32'h55};
        bus.rd_valid = 2'b01;
        bus.rd_addr  = {2'd0, 2'd3};
        #1;
        chk("coll_wr_ready", bus.wr_ready, 2'b01);
        chk("coll_rd_ready", bus.rd_ready, 2'b01);
        chk("coll_raddr",    bus.ram_raddr, 2'd3);
        ref_mem[3] = 32'h55;

        @(negedge clk);
        idle_inputs();
`ifdef SRSW_ARB_BYPASS_EN
        exp_coll = 32'h55;
`else
        exp_coll = 32'h11;
`endif
        #1;
        chk("coll_resp_vld",  bus.resp_valid, 2'b01);
        chk("coll_resp_data", bus.resp_data, exp_coll);

        // read by requester 0, then reset drops the response
        @(negedge clk);
        bus.rd_valid = 2'b01;
        bus.rd_addr  = {2'd0, 2'd1};
        #1;
        chk("prerst_rd_ready", bus.rd_ready, 2'b01);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("rst_drop_vld",  bus.resp_valid, 2'b00);
        chk("rst_drop_data", bus.resp_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("after_rst_no_resp", bus.resp_valid, 2'b00);

        // contention after reset: requester 0 must win both ports
        @(negedge clk);
        bus.wr_valid = 2'b11;
        bus.wr_addr  = {2'd1, 2'd0};
        bus.wr_data  = {32'h101, 32'h100};
        bus.rd_valid = 2'b11;
        bus.rd_addr  = {2'd3, 2'd2};
        #1;
        chk("ptr_rst_wr_ready", bus.wr_ready, 2'b01);
        chk("ptr_rst_rd_ready", bus.rd_ready, 2'b01);
        ref_mem[0] = 32'h100;
        prev_oh    = 2'b01;
        prev_data  = ref_mem[2];

        // back-to-back reads, both requesters always requesting
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            idle_inputs();
            a0 = 2'(i % 4);
            a1 = 2'((i + 1) % 4);
            bus.rd_valid = 2'b11;
            bus.rd_addr  = {a1, a0};
            #1;
            gid = (i % 2 == 0) ? 1 : 0;
            chk("b2b_rd_ready",  bus.rd_ready, (gid == 1) ? 2'b10 : 2'b01);
            chk("b2b_raddr",     bus.ram_raddr, (gid == 1) ? a1 : a0);
            chk("b2b_resp_vld",  bus.resp_valid, prev_oh);
            chk("b2b_resp_data", bus.resp_data, prev_data);
            prev_oh   = (gid == 1) ? 2'b10 : 2'b01;
            prev_data = ref_mem[(gid == 1) ? a1 : a0];
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk("b2b_last_vld",  bus.resp_valid, prev_oh);
        chk("b2b_last_data", bus.resp_data, prev_data);
        @(negedge clk);
        #1;
        chk("b2b_drain", bus.resp_valid, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
